// File: rtl/serializador_valid_4b.sv
// serializador_valid_4b: MSB-first serializer with one-word hold buffer, idle fill and sticky overflow
module serializador_valid_4b #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD = 4'b1100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             data_out,
  output logic             valid_out,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, DATA} state_t;
  logic [WIDTH-1:0] sr_q, sr_d, hr_q, hr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold_full_q, hold_full_d, overflow_q, overflow_d;
  state_t state_q, state_d;
  logic accept, boundary, bypass;
  assign ready     = !reset && !hold_full_q;
  assign accept    = valid_in && ready;
  assign boundary  = cnt_q == CW'(WIDTH - 1);
  // a word accepted at a boundary with an empty hold skips HR and loads SR directly
  assign bypass    = boundary && !hold_full_q && accept;
  assign data_out  = sr_q[WIDTH-1];
  assign valid_out = state_q == DATA;
  assign overflow  = overflow_q;
  always_comb begin
    sr_d        = !boundary ? {sr_q[WIDTH-2:0], 1'b0} : hold_full_q ? hr_q : accept ? data_in : IDLE_WORD;
    cnt_d       = boundary ? '0 : cnt_q + CW'(1);
    hr_d        = (accept && !bypass) ? data_in : hr_q;
    hold_full_d = boundary ? (hold_full_q && accept) : (hold_full_q || accept);
    state_d     = !boundary ? state_q : (hold_full_q || accept) ? DATA : IDLE;
    overflow_d  = overflow_q || (valid_in && !ready && !reset);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q        <= '0;
      cnt_q       <= CW'(WIDTH - 1);
      hr_q        <= '0;
      hold_full_q <= 1'b0;
      state_q     <= IDLE;
      overflow_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      hr_q        <= hr_d;
      hold_full_q <= hold_full_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_serializador_valid_4b.sv
// tb_serializador_valid_4b: scenario and random checks of the serializer against a queue-based word model
module tb_serializador_valid_4b;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] data_in = '0;
  logic valid_in = 1'b0;
  logic ready, data_out, valid_out, overflow;
  int checks = 0;
  int errors = 0;
  logic [3:0] m_w = '0;
  logic m_v = 1'b0;
  logic m_ov = 1'b0;
  int m_k = 3;
  logic [3:0] m_q[$];
  wire [3:0] got = {ready, data_out, valid_out, overflow};

  serializador_valid_4b dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready(ready), .data_out(data_out), .valid_out(valid_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] expv();
    return {!reset && m_q.size() == 0, m_w[3 - m_k], m_v, m_ov};
  endfunction

  // drive one cycle and advance the word-level model: words wait in a queue, slots are 4 edges long
  task automatic cyc(input logic r, input logic v, input logic [3:0] d);
    @(negedge clk);
    reset = r; valid_in = v; data_in = d;
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_w = '0; m_v = 1'b0; m_k = 3; m_ov = 1'b0;
    end else begin
      if (v && m_q.size() == 0) m_q.push_back(d);
      else if (v) m_ov = 1'b1;
      if (m_k == 3) begin
        m_k = 0;
        if (m_q.size() > 0) begin m_w = m_q.pop_front(); m_v = 1'b1; end
        else begin m_w = 4'b1100; m_v = 1'b0; end
      end else m_k++;
    end
    #1;
  endtask

  task automatic align(input int k);
    for (int i = 0; i < 8 && m_k != k; i++) cyc(0, 0, 0);
  endtask

  task automatic test_reset();
    logic [3:0] pat = 4'b1100;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    checks++;
    if (got !== 4'b0000) begin errors++; $display("FAIL reset rdy/dout/vout/ovf got %b exp 0000", got); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0);
      checks++;
      if (got !== expv() || data_out !== pat[3 - i % 4] || valid_out !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc %0d got %b exp %b idle bit %b", i, got, expv(), pat[3 - i % 4]);
      end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] ed = 8'b1011_1100;
    logic [7:0] ev = 8'b1111_0000;
    align(3);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) cyc(0, 1, 4'b1011); else cyc(0, 0, 0);
      checks++;
      if (got !== expv() || data_out !== ed[7 - i] || valid_out !== ev[7 - i]) begin
        errors++; $display("FAIL single_word cyc %0d got %b exp %b bit %b valid %b", i, got, expv(), ed[7 - i], ev[7 - i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ed = 12'b0001_1110_1100;
    logic [11:0] ev = 12'b1111_1111_0000;
    align(3);
    for (int i = 0; i < 12; i++) begin
      if (i == 0) cyc(0, 1, 4'b0001);
      else if (i == 1) cyc(0, 1, 4'b1110);
      else cyc(0, 0, 0);
      checks++;
      if (got !== expv() || data_out !== ed[11 - i] || valid_out !== ev[11 - i]) begin
        errors++; $display("FAIL back_to_back cyc %0d got %b exp %b bit %b valid %b", i, got, expv(), ed[11 - i], ev[11 - i]);
      end
    end
  endtask

  task automatic test_hold_latency();
    logic [3:0] w = 4'b0110;
    int lat = 1;
    align(1);
    cyc(0, 1, 4'b0110);
    checks++;
    if (got !== expv() || ready !== 1'b0) begin errors++; $display("FAIL hold_full got %b exp %b", got, expv()); end
    while (!valid_out && lat < 10) begin
      cyc(0, 0, 0);
      lat++;
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL hold_latency got %0d edges exp 3", lat); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc(0, 0, 0);
      checks++;
      if (got !== expv() || data_out !== w[3 - i] || valid_out !== 1'b1) begin
        errors++; $display("FAIL hold_word bit %0d got %b exp %b bit %b", i, got, expv(), w[3 - i]);
      end
    end
  endtask

  task automatic test_full_rate();
    logic [3:0] n = 4'd1;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, n);
      n++;
      checks++;
      if (got !== expv()) begin errors++; $display("FAIL full_rate cyc %0d got %b exp %b", i, got, expv()); end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_rate_overflow got %b exp 1", overflow); end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] pat = 4'b1100;
    align(3);
    cyc(0, 1, 4'b1010);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    checks++;
    if (got !== 4'b0000) begin errors++; $display("FAIL mid_reset got %b exp 0000", got); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0);
      checks++;
      if (got !== expv() || data_out !== pat[3 - i % 4] || valid_out !== 1'b0) begin
        errors++; $display("FAIL mid_reset_idle cyc %0d got %b exp %b", i, got, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 4'($urandom));
      checks++;
      if (got !== expv()) begin errors++; $display("FAIL random cyc %0d got %b exp %b", i, got, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_hold_latency();
    test_full_rate();
    test_reset_mid_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
